seven_seg_scan_driver: RTL and testbench

//  Downstream display stage of riscv_processor. Takes the 16-bit debug value produced by the core
//  (PC, ALU result or instruction bits, selected upstream) and drives the board's 4-digit

---
 rtl/seven_seg_scan_driver_if.sv | 21 ++
 rtl/seven_seg_scan_driver.sv | 135 +++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_driver_if.sv
// Display-side bus of seven_seg_scan_driver: the value/load/decimal-point inputs
// from the core and the multiplexed segment/anode outputs toward the board.
interface seven_seg_scan_driver_if;
  logic [15:0] disp_value;
  logic        disp_load;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  modport master (
    output disp_value, disp_load, dp_in,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  disp_value, disp_load, dp_in,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode hex display driver with frame-boundary double buffering.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input logic                  clk,
  input logic                  reset_n,
  seven_seg_scan_driver_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [CW-1:0] div_cnt_r, div_cnt_next;
  logic [1:0]    digit_idx_r, digit_idx_next;
  logic [15:0]   active_r, active_next;
  logic [15:0]   pending_r, pending_next;
  logic          pending_valid_r, pending_valid_next;
  logic [6:0]    seg_r, seg_next;
  logic [3:0]    an_r, an_next;
  logic          dp_r, dp_next;
  logic          frame_done_r, frame_done_next;
  logic          div_wrap;
  logic          boundary;
  logic [3:0]    nibble;
  logic          blank;

  // Scan counters; frame_done is registered one cycle early so it is high during the boundary cycle
  always_comb begin
    div_wrap        = (div_cnt_r == LAST);
    boundary        = div_wrap && (digit_idx_r == 2'd3);
    div_cnt_next    = div_wrap ? {CW{1'b0}} : div_cnt_r + CW'(1);
    digit_idx_next  = div_wrap ? digit_idx_r + 2'd1 : digit_idx_r;
    frame_done_next = (div_cnt_next == LAST) && (digit_idx_next == 2'd3);
  end

  // Double buffer: a load on the boundary cycle bypasses pending straight into active
  always_comb begin
    active_next        = active_r;
    pending_next       = pending_r;
    pending_valid_next = pending_valid_r;
    if (bus.disp_load && boundary) begin
      active_next        = bus.disp_value;
      pending_next       = bus.disp_value;
      pending_valid_next = 1'b0;
    end else if (bus.disp_load) begin
      pending_next       = bus.disp_value;
      pending_valid_next = 1'b1;
    end else if (boundary && pending_valid_r) begin
      active_next        = pending_r;
      pending_valid_next = 1'b0;
    end else begin
      active_next        = active_r;
    end
  end

  // Digit decode from the current scan position
  always_comb begin
    case (digit_idx_r)
      2'd0:    nibble = active_r[3:0];
      2'd1:    nibble = active_r[7:4];
      2'd2:    nibble = active_r[11:8];
      2'd3:    nibble = active_r[15:12];
      default: nibble = 4'h0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (digit_idx_r)
      2'd1:    blank = (active_r[15:4] == 12'h000);
      2'd2:    blank = (active_r[15:8] == 8'h00);
      2'd3:    blank = (active_r[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    seg_next = blank ? 7'h7F : hex_to_seg(nibble);
    an_next  = ~(4'b0001 << digit_idx_r);
    dp_next  = ~bus.dp_in[digit_idx_r];
  end

  // State and registered display outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r       <= {CW{1'b0}};
      digit_idx_r     <= 2'd0;
      active_r        <= 16'h0000;
      pending_r       <= 16'h0000;
      pending_valid_r <= 1'b0;
      seg_r           <= 7'h7F;
      an_r            <= 4'hF;
      dp_r            <= 1'b1;
      frame_done_r    <= 1'b0;
    end else begin
      div_cnt_r       <= div_cnt_next;
      digit_idx_r     <= digit_idx_next;
      active_r        <= active_next;
      pending_r       <= pending_next;
      pending_valid_r <= pending_valid_next;
      seg_r           <= seg_next;
      an_r            <= an_next;
      dp_r            <= dp_next;
      frame_done_r    <= frame_done_next;
    end
  end

  assign bus.seg        = seg_r;
  assign bus.an         = an_r;
  assign bus.dp         = dp_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with REFRESH_DIV=4 (16-cycle frames).
module tb_seven_seg_scan_driver;

  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S2 = 7'h24;
  localparam logic [6:0] S3 = 7'h30;
  localparam logic [6:0] S5 = 7'h12;
  localparam logic [6:0] SA = 7'h08;
  localparam logic [6:0] SC = 7'h46;
  localparam logic [6:0] SF = 7'h0E;
  localparam logic [6:0] BL = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZH = BL;
`else
  localparam logic [6:0] ZH = S0;
`endif

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  seven_seg_scan_driver_if bus ();

  seven_seg_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v);
    bus.disp_value = v;
    bus.disp_load  = 1'b1;
    @(negedge clk);
    bus.disp_load  = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {15'd0, bus.frame_done}, 16'd1);
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    reset_n        = 1'b0;
    bus.disp_value = 16'h0000;
    bus.disp_load  = 1'b0;
    bus.dp_in      = 4'b0000;

    // 1. reset values, scan order, frame period
    step(3);
    chk("rst_an",  {12'd0, bus.an}, 16'h000F);
    chk("rst_seg", {9'd0, bus.seg}, 16'h007F);
    chk("rst_dp",  {15'd0, bus.dp}, 16'h0001);
    chk("rst_fd",  {15'd0, bus.frame_done}, 16'h0000);
    reset_n = 1'b1;
    step(1);
    chk("first_an",  {12'd0, bus.an}, 16'h000E);
    chk("first_seg", {9'd0, bus.seg}, {9'd0, S0});
    chk("first_dp",  {15'd0, bus.dp}, 16'h0001);
    chk("first_fd",  {15'd0, bus.frame_done}, 16'h0000);
    step(4);
    chk("scan_an1", {12'd0, bus.an}, 16'h000D);
    step(4);
    chk("scan_an2", {12'd0, bus.an}, 16'h000B);
    step(4);
    chk("scan_an3", {12'd0, bus.an}, 16'h0007);
    step(2);
    chk("fd_first", {15'd0, bus.frame_done}, 16'h0001);
    step(1);
    chk("fd_pulse_end", {15'd0, bus.frame_done}, 16'h0000);
    step(14);
    chk("fd_pre", {15'd0, bus.frame_done}, 16'h0000);
    step(1);
    chk("fd_period16", {15'd0, bus.frame_done}, 16'h0001);

    // 2. mid-frame load is deferred to the next frame
    bus.dp_in = 4'b0100;
    step(2);
    load(16'h12AF);
    chk("defer_d0", {9'd0, bus.seg}, {9'd0, S0});
    step(4);
    chk("defer_an1", {12'd0, bus.an}, 16'h000D);
    chk("defer_d1", {9'd0, bus.seg}, {9'd0, ZH});
    wait_fd("t2_fd");
    chk("defer_d3", {9'd0, bus.seg}, {9'd0, ZH});
    step(2);
    chk("t2_an0", {12'd0, bus.an}, 16'h000E);
    chk("t2_d0",  {9'd0, bus.seg}, {9'd0, SF});
    chk("t2_dp0", {15'd0, bus.dp}, 16'h0001);
    step(4);
    chk("t2_d1", {9'd0, bus.seg}, {9'd0, SA});
    step(4);
    chk("t2_an2", {12'd0, bus.an}, 16'h000B);
    chk("t2_d2",  {9'd0, bus.seg}, {9'd0, S2});
    chk("t2_dp2", {15'd0, bus.dp}, 16'h0000);
    step(4);
    chk("t2_d3", {9'd0, bus.seg}, {9'd0, S1});
    bus.dp_in = 4'b0000;

    // 3. last load in a frame wins
    wait_fd("t3_fd0");
    step(2);
    load(16'h1111);
    load(16'h2222);
    wait_fd("t3_fd1");
    step(2);
    for (int d = 0; d < 4; d++) begin
      chk("t3_an",  {12'd0, bus.an}, {12'd0, ~(4'b0001 << d)});
      chk("t3_seg", {9'd0, bus.seg}, {9'd0, S2});
      if (d < 3) step(4);
    end

    // 4. load on the boundary cycle goes straight to active
    wait_fd("t4_fd");
    load(16'h00C3);
    chk("t4_pv", {15'd0, dut.pending_valid_r}, 16'h0000);
    step(1);
    chk("t4_an0", {12'd0, bus.an}, 16'h000E);
    chk("t4_d0",  {9'd0, bus.seg}, {9'd0, S3});
    step(4);
    chk("t4_an1", {12'd0, bus.an}, 16'h000D);
    chk("t4_d1",  {9'd0, bus.seg}, {9'd0, SC});
    step(4);
    chk("t4_d2", {9'd0, bus.seg}, {9'd0, ZH});

    // 5. leading zeros
    load(16'h0050);
    wait_fd("t5_fd");
    step(2);
    chk("t5_d0", {9'd0, bus.seg}, {9'd0, S0});
    step(4);
    chk("t5_d1", {9'd0, bus.seg}, {9'd0, S5});
    step(4);
    chk("t5_d2", {9'd0, bus.seg}, {9'd0, ZH});
    step(4);
    chk("t5_d3", {9'd0, bus.seg}, {9'd0, ZH});

    // 6. reset before the boundary discards pending data
    load(16'hFFFF);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_an",  {12'd0, bus.an}, 16'h000F);
    chk("t6_rst_seg", {9'd0, bus.seg}, 16'h007F);
    chk("t6_rst_fd",  {15'd0, bus.frame_done}, 16'h0000);
    step(2);
    reset_n = 1'b1;
    step(1);
    chk("t6_first_an",  {12'd0, bus.an}, 16'h000E);
    chk("t6_first_seg", {9'd0, bus.seg}, {9'd0, S0});
    wait_fd("t6_fd");
    step(2);
    chk("t6_d0", {9'd0, bus.seg}, {9'd0, S0});
    step(4);
    chk("t6_d1", {9'd0, bus.seg}, {9'd0, ZH});
    step(4);
    chk("t6_d2", {9'd0, bus.seg}, {9'd0, ZH});
    step(4);
    chk("t6_d3", {9'd0, bus.seg}, {9'd0, ZH});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
